gpu_vram_write_unpacker: RTL and testbench

- Consumer stage behind the GP0 first-word-fall-through command/data FIFO during a CPU->VRAM image transfer (GP0 0xA0 data phase).
- Pops 32-bit words and splits each into two 16-bit pixels, low half first.
- Each pixel is tagged with its wrapped VRAM coordinate and sent to the VRAM write arbiter over a valid/ready handshake.
- Handles odd pixel counts, PSX size encoding (0 = max), coordinate wrap, abort and backpressure.

---
 rtl/gpu_vram_write_unpacker_pkg.sv | 23 ++
 rtl/gpu_vram_write_unpacker_if.sv | 34 +++
 rtl/gpu_vram_write_unpacker_rect_walker.sv | 67 ++++++
 rtl/gpu_vram_write_unpacker.sv | 109 ++++++++++
 tb/tb_gpu_vram_write_unpacker.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_vram_write_unpacker_pkg.sv
// Shared GPU definitions for the VRAM transfer stages: coordinate types,
// VRAM geometry and the transfer state encoding.
`timescale 1ns/1ps
package gpu_vram_write_unpacker_pkg;

    localparam int VRAM_W = 1024;
    localparam int VRAM_H = 512;

    typedef logic [9:0] vram_x_t;
    typedef logic [8:0] vram_y_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } wr_state_e;

    // Each FIFO word carries two pixels, the low half goes out first.
    function automatic logic [15:0] pick_half(input logic [31:0] word, input logic half);
        return half ? word[31:16] : word[15:0];
    endfunction

endpackage

// File: rtl/gpu_vram_write_unpacker_if.sv
// Control, FIFO-head and pixel-stream signals of the CPU->VRAM write unpacker.
`timescale 1ns/1ps
interface gpu_vram_write_unpacker_if #(
    parameter int X_BITS = 10,
    parameter int Y_BITS = 9
) ();
    logic              start;
    logic              abort;
    logic [X_BITS-1:0] x0;
    logic [Y_BITS-1:0] y0;
    logic [X_BITS-1:0] w;
    logic [Y_BITS-1:0] h;
    logic [31:0]       fifo_dout;
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic              pix_valid;
    logic              pix_ready;
    logic [15:0]       pix_data;
    logic [X_BITS-1:0] pix_x;
    logic [Y_BITS-1:0] pix_y;
    logic              pix_last;
    logic              busy;
    logic              done;

    modport master (
        input  start, abort, x0, y0, w, h, fifo_dout, fifo_empty, pix_ready,
        output fifo_rd_en, pix_valid, pix_data, pix_x, pix_y, pix_last, busy, done
    );

    modport slave (
        output start, abort, x0, y0, w, h, fifo_dout, fifo_empty, pix_ready,
        input  fifo_rd_en, pix_valid, pix_data, pix_x, pix_y, pix_last, busy, done
    );
endinterface

// File: rtl/gpu_vram_write_unpacker_rect_walker.sv
// Raster walker over a wrapped VRAM rectangle: column/row counters, origin
// adders and final-pixel detect. Shared by the VRAM transfer stages.
`timescale 1ns/1ps
module gpu_rect_walker #(
    parameter int X_BITS = 10,
    parameter int Y_BITS = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [X_BITS-1:0] x0,
    input  logic [Y_BITS-1:0] y0,
    input  logic [X_BITS-1:0] w,
    input  logic [Y_BITS-1:0] h,
    output logic [X_BITS-1:0] x,
    output logic [Y_BITS-1:0] y,
    output logic              last
);
    localparam logic [X_BITS:0] X_ONE = {{X_BITS{1'b0}}, 1'b1};
    localparam logic [Y_BITS:0] Y_ONE = {{Y_BITS{1'b0}}, 1'b1};

    logic [X_BITS-1:0] x0_reg;
    logic [Y_BITS-1:0] y0_reg;
    logic [X_BITS:0]   wl_reg;
    logic [Y_BITS:0]   hl_reg;
    logic [X_BITS:0]   col_reg;
    logic [Y_BITS:0]   row_reg;
    logic              col_end;
    logic              row_end;

    // A zero size field means the full 2^N extent: the extra top bit is set
    // exactly when the field is zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            x0_reg  <= '0;
            y0_reg  <= '0;
            wl_reg  <= '0;
            hl_reg  <= '0;
            col_reg <= '0;
            row_reg <= '0;
        end else if (load) begin
            x0_reg  <= x0;
            y0_reg  <= y0;
            wl_reg  <= {(w == '0), w};
            hl_reg  <= {(h == '0), h};
            col_reg <= '0;
            row_reg <= '0;
        end else if (step) begin
            if (col_end) begin
                col_reg <= '0;
                row_reg <= row_reg + Y_ONE;
            end else begin
                col_reg <= col_reg + X_ONE;
            end
        end
    end

    assign col_end = (col_reg == wl_reg - X_ONE);
    assign row_end = (row_reg == hl_reg - Y_ONE);
    assign last    = col_end && row_end;

    // Truncating add gives the modulo-2^N wrap for free.
    assign x = x0_reg + col_reg[X_BITS-1:0];
    assign y = y0_reg + row_reg[Y_BITS-1:0];

endmodule

// File: rtl/gpu_vram_write_unpacker.sv
// GP0 CPU->VRAM data-phase consumer: pops 32-bit FWFT words and emits two
// coordinate-tagged 16-bit pixels per word to the VRAM write arbiter.
`timescale 1ns/1ps
module gpu_vram_write_unpacker
    import gpu_vram_write_unpacker_pkg::*;
#(
    parameter int X_BITS = 10,
    parameter int Y_BITS = 9
) (
    input  logic                       clk,
    input  logic                       rst,
    gpu_vram_write_unpacker_if.master  bus
);
    wr_state_e state_reg, state_next;
    logic      half_reg, half_next;

    logic      valid_int;
    logic      rd_en_int;
    logic      done_int;
    logic      walk_load;
    logic      walk_step;
    logic      walk_last;

    logic [X_BITS-1:0] walk_x;
    logic [Y_BITS-1:0] walk_y;

    gpu_rect_walker #(
        .X_BITS (X_BITS),
        .Y_BITS (Y_BITS)
    ) u_walker (
        .clk  (clk),
        .rst  (rst),
        .load (walk_load),
        .step (walk_step),
        .x0   (bus.x0),
        .y0   (bus.y0),
        .w    (bus.w),
        .h    (bus.h),
        .x    (walk_x),
        .y    (walk_y),
        .last (walk_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            half_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            half_reg  <= half_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        half_next  = half_reg;
        valid_int  = 1'b0;
        rd_en_int  = 1'b0;
        done_int   = 1'b0;
        walk_load  = 1'b0;
        walk_step  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = RUN;
                    half_next  = 1'b0;
                    walk_load  = 1'b1;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_next = IDLE;
                end else begin
                    valid_int = !bus.fifo_empty;
                    if (valid_int && bus.pix_ready) begin
                        walk_step = 1'b1;
                        // The final pixel always retires its word, even when the
                        // upper half is padding for an odd pixel count.
                        if (walk_last) begin
                            rd_en_int  = 1'b1;
                            half_next  = 1'b0;
                            state_next = DONE;
                        end else if (half_reg) begin
                            rd_en_int = 1'b1;
                            half_next = 1'b0;
                        end else begin
                            half_next = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                done_int   = !bus.abort;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.fifo_rd_en = rd_en_int;
    assign bus.pix_valid  = valid_int;
    assign bus.pix_data   = pick_half(bus.fifo_dout, half_reg);
    assign bus.pix_x      = walk_x;
    assign bus.pix_y      = walk_y;
    assign bus.pix_last   = valid_int && walk_last;
    assign bus.busy       = (state_reg != IDLE);
    assign bus.done       = done_int;

endmodule

// File: tb/tb_gpu_vram_write_unpacker.sv
// Scoreboard bench for gpu_vram_write_unpacker: a FIFO model feeds random or
// fixed words, expected pixels come from the raster rules, a monitor compares.
`timescale 1ns/1ps
module tb_gpu_vram_write_unpacker;

    localparam int XB = 10;
    localparam int YB = 9;

    typedef struct packed {
        logic [15:0] d;
        logic [9:0]  x;
        logic [8:0]  y;
        logic        last;
    } pix_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gpu_vram_write_unpacker_if #(.X_BITS(XB), .Y_BITS(YB)) bus ();

    gpu_vram_write_unpacker #(.X_BITS(XB), .Y_BITS(YB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] fifo_q[$];
    logic [31:0] fixed_q[$];
    pix_t        exp_q[$];

    bit  rand_mode   = 1'b0;
    bit  pop_pending = 1'b0;
    int  pop_cnt  = 0;
    int  acc_cnt  = 0;
    int  done_cnt = 0;

    int  done_target;
    int  pop_base;
    int  exp_pops;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // FIFO model: pops on the edge after the monitor saw fifo_rd_en, then
    // presents the new head (or a random starvation gap) just after the edge.
    initial begin
        bit gap;
        bus.fifo_empty = 1'b1;
        bus.fifo_dout  = '0;
        bus.pix_ready  = 1'b1;
        forever begin
            @(posedge clk);
            if (pop_pending && fifo_q.size() > 0) void'(fifo_q.pop_front());
            #1;
            gap           = rand_mode ? ($urandom_range(0, 3) == 0) : 1'b0;
            bus.pix_ready = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (fifo_q.size() > 0 && !gap) begin
                bus.fifo_empty = 1'b0;
                bus.fifo_dout  = fifo_q[0];
            end else begin
                bus.fifo_empty = 1'b1;
                bus.fifo_dout  = $urandom;
            end
        end
    end

    // Monitor
    initial begin
        bit   prev_stall;
        bit   prev_done;
        bit   prev_last_acc;
        pix_t prev_pix;
        pix_t cur;
        pix_t e;
        prev_stall = 0; prev_done = 0; prev_last_acc = 0; prev_pix = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pop_pending = 0; prev_stall = 0; prev_done = 0; prev_last_acc = 0;
            end else begin
                cur = '{bus.pix_data, bus.pix_x, bus.pix_y, bus.pix_last};
                pop_pending = bus.fifo_rd_en;
                if (bus.fifo_rd_en) begin
                    pop_cnt++;
                    check("pop_while_empty", {63'd0, bus.fifo_empty}, 64'd0);
                end
                if (bus.pix_valid && prev_stall)
                    check("stall_stable", {28'd0, cur}, {28'd0, prev_pix});
                if (bus.pix_valid && bus.pix_ready) begin
                    acc_cnt++;
                    if (exp_q.size() == 0) begin
                        check("extra_pixel", {28'd0, cur}, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("pixel", {28'd0, cur}, {28'd0, e});
                    end
                end
                if (bus.done) begin
                    done_cnt++;
                    check("done_after_last", {63'd0, prev_last_acc}, 64'd1);
                    check("done_single", {63'd0, prev_done}, 64'd0);
                end
                prev_done     = bus.done;
                prev_last_acc = bus.pix_valid && bus.pix_ready && bus.pix_last;
                prev_stall    = bus.pix_valid && !bus.pix_ready;
                prev_pix      = cur;
            end
        end
    end

    task automatic pulse_start(input int ix, input int iy, input int iw, input int ih, input bit with_abort);
        @(posedge clk); #2;
        bus.x0 = XB'(ix); bus.y0 = YB'(iy); bus.w = XB'(iw); bus.h = YB'(ih);
        bus.start = 1'b1; bus.abort = with_abort;
        @(posedge clk); #2;
        bus.start = 1'b0; bus.abort = 1'b0;
    endtask

    // Expected pixels straight from the raster rules: pixel i comes from word
    // i/2, half i%2, at ((x0 + i%W) mod 1024, (y0 + i/W) mod 512).
    task automatic issue(input int ix, input int iy, input int iw, input int ih, input bit with_abort);
        int wl, hl, n, nw;
        logic [31:0] words[$];
        logic [31:0] wd;
        pix_t p;
        wl = (iw == 0) ? 1024 : iw;
        hl = (ih == 0) ? 512 : ih;
        n  = wl * hl;
        nw = (n + 1) / 2;
        for (int k = 0; k < nw; k++) begin
            wd = (k < fixed_q.size()) ? fixed_q[k] : $urandom;
            words.push_back(wd);
            fifo_q.push_back(wd);
        end
        fixed_q.delete();
        for (int i = 0; i < n; i++) begin
            wd     = words[i / 2];
            p.d    = (i % 2 == 1) ? wd[31:16] : wd[15:0];
            p.x    = 10'((ix + i % wl) % 1024);
            p.y    = 9'((iy + i / wl) % 512);
            p.last = (i == n - 1);
            exp_q.push_back(p);
        end
        done_target = done_cnt + 1;
        pop_base    = pop_cnt;
        exp_pops    = nw;
        pulse_start(ix, iy, iw, ih, with_abort);
    endtask

    task automatic finish_transfer(input string name);
        bit ok;
        ok = 0;
        for (int c = 0; c < 20000; c++) begin
            @(posedge clk);
            if (done_cnt >= done_target) begin ok = 1; break; end
        end
        if (!ok) check({name, "_timeout"}, 64'(done_cnt), 64'(done_target));
        @(negedge clk);
        check({name, "_busy_after"}, {63'd0, bus.busy}, 64'd0);
        check({name, "_pops"}, 64'(pop_cnt - pop_base), 64'(exp_pops));
        check({name, "_exp_left"}, 64'(exp_q.size()), 64'd0);
        check({name, "_fifo_left"}, 64'(fifo_q.size()), 64'd0);
        $display("transfer %s: pixels ok=%0d pops=%0d", name, ok, pop_cnt - pop_base);
    endtask

    task automatic wait_accepts(input int base, input int cnt, input string name);
        bit ok;
        ok = 0;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk);
            if (acc_cnt - base >= cnt) begin ok = 1; break; end
        end
        if (!ok) check({name, "_timeout"}, 64'(acc_cnt - base), 64'(cnt));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, dbase;
        rst = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.x0 = '0; bus.y0 = '0; bus.w = '0; bus.h = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("reset_valid", {63'd0, bus.pix_valid}, 64'd0);
        check("reset_rd_en", {63'd0, bus.fifo_rd_en}, 64'd0);
        check("reset_last",  {63'd0, bus.pix_last}, 64'd0);
        check("reset_busy",  {63'd0, bus.busy}, 64'd0);
        check("reset_done",  {63'd0, bus.done}, 64'd0);
        $display("reset: checked idle outputs");

        // 2x2 at (10,20)
        fixed_q.push_back(32'h2222_1111); fixed_q.push_back(32'h4444_3333);
        issue(10, 20, 2, 2, 1'b0);
        finish_transfer("rect2x2");

        // odd 3x1: upper half of the second word is never shown
        fixed_q.push_back(32'hBBBB_AAAA); fixed_q.push_back(32'hDDDD_CCCC);
        issue(0, 0, 3, 1, 1'b0);
        finish_transfer("odd3x1");

        issue(1023, 511, 2, 2, 1'b0);
        finish_transfer("wrap");

        issue(100, 7, 0, 1, 1'b0);
        finish_transfer("width0");

        // same fixed picture under backpressure and starvation
        rand_mode = 1'b1;
        fixed_q.push_back(32'h2222_1111); fixed_q.push_back(32'h4444_3333);
        issue(10, 20, 2, 2, 1'b0);
        finish_transfer("rect2x2_rand");

        for (int t = 0; t < 6; t++) begin
            issue($urandom_range(0, 1023), $urandom_range(0, 511),
                  $urandom_range(1, 24), $urandom_range(1, 6), 1'b0);
            finish_transfer("random");
        end

        // start while busy must not disturb the running transfer
        issue(1000, 500, 16, 4, 1'b0);
        repeat (5) @(posedge clk);
        pulse_start(3, 3, 2, 2, 1'b0);
        finish_transfer("start_busy");

        // start and abort together in IDLE: start wins
        issue(50, 60, 5, 3, 1'b1);
        finish_transfer("start_abort");

        // abort after 3 of 8 pixels
        rand_mode = 1'b0;
        base  = acc_cnt;
        dbase = done_cnt;
        issue(5, 5, 4, 2, 1'b0);
        wait_accepts(base, 3, "abort_wait");
        #2 bus.abort = 1'b1;
        @(negedge clk);
        check("abort_valid", {63'd0, bus.pix_valid}, 64'd0);
        check("abort_rd_en", {63'd0, bus.fifo_rd_en}, 64'd0);
        @(posedge clk); #2 bus.abort = 1'b0;
        @(negedge clk);
        check("abort_busy", {63'd0, bus.busy}, 64'd0);
        check("abort_pops", 64'(pop_cnt - pop_base), 64'd1);
        repeat (2) @(negedge clk);
        check("abort_no_done", 64'(done_cnt), 64'(dbase));
        exp_q.delete(); fifo_q.delete();
        $display("abort: pops=%0d accepts=%0d", pop_cnt - pop_base, acc_cnt - base);

        // rst in the middle of a transfer
        base  = acc_cnt;
        dbase = done_cnt;
        issue(0, 0, 8, 8, 1'b0);
        wait_accepts(base, 5, "rst_wait");
        #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        check("rst_valid", {63'd0, bus.pix_valid}, 64'd0);
        check("rst_rd_en", {63'd0, bus.fifo_rd_en}, 64'd0);
        check("rst_last",  {63'd0, bus.pix_last}, 64'd0);
        check("rst_busy",  {63'd0, bus.busy}, 64'd0);
        check("rst_done",  {63'd0, bus.done}, 64'd0);
        check("rst_no_done", 64'(done_cnt), 64'(dbase));
        @(posedge clk); #2;
        exp_q.delete(); fifo_q.delete();
        $display("rst: mid-transfer reset checked");

        // recovery after reset
        rand_mode = 1'b1;
        issue(511, 255, 7, 3, 1'b0);
        finish_transfer("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
